a2d_arbiter: RTL
================

Name: a2d_arbiter

Overview:
- Shares the single SPI A2D converter between two requesters: requester 0 (the motion controller's IR round-robin) and requester 1 (an auxiliary sampler, e.g. battery or spare channel).
- Buffers one request per requester and grants the converter by round-robin or fixed priority.
- Sequences strt_cnv and chnnl, and returns the latched result with a per-requester completion pulse.
- Sits in dig_core between the requesters and the A2D interface.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties.
TO_CYCLES, 4096, conversion timeout in clk cycles (used only with A2D_TIMEOUT_EN).

Ports:
clk  input  1  50 MHz system clock.
rst_n  input  1  asynchronous active-low reset.
req0_strt  input  1  one-cycle request pulse from requester 0.
req0_chnnl  input  3  channel for requester 0, sampled with req0_strt.
req1_strt  input  1  one-cycle request pulse from requester 1.
req1_chnnl  input  3  channel for requester 1, sampled with req1_strt.
strt_cnv  output  1  one-cycle start pulse to the A2D interface.
chnnl  output  3  channel to the A2D interface, stable from strt_cnv until completion.
cnv_cmplt  input  1  A2D conversion done.
A2D_res  input  12  A2D result, valid with cnv_cmplt.
res  output  12  latched result of the last completed conversion.
cmplt0  output  1  one-cycle pulse: res belongs to requester 0.
cmplt1  output  1  one-cycle pulse: res belongs to requester 1.
busy0  output  1  requester 0 has a pending or in-flight conversion.
busy1  output  1  requester 1 has a pending or in-flight conversion.
to_err  output  1  one-cycle timeout pulse (feature only, else 0).

Behaviour:
- Reset values: state IDLE, strt_cnv=0, chnnl=0, res=0, cmplt0=0, cmplt1=0, busy0=0, busy1=0, to_err=0. Pending flags and stored channels are cleared; the round-robin pointer points at requester 0 (requester 0 wins the first tie). Reset mid-conversion abandons the conversion; a later stray cnv_cmplt is ignored.
- Request capture: reqN_strt sets pendN and stores reqN_chnnl at the next edge.
  - reqN while pendN=1 and not yet granted: overwrites the stored channel; still a single request.
  - reqN while N's own conversion is in flight: sets pendN again for a follow-on conversion. Set wins over the clear at completion.
- busyN = pendN OR (in flight AND grant==N).
- State IDLE:
  - If any pendN, choose the winner. Round-robin: prefer the requester not granted last. FIXED_PRIO=1: requester 0 wins.
  - At the next edge: go to START, register chnnl = stored channel, register strt_cnv=1, record the grant, and clear the winner's pendN.
- State START: exactly one cycle with strt_cnv=1. Next edge: strt_cnv=0, go to WAIT.
- State WAIT:
  - chnnl is held.
  - On cnv_cmplt=1: at the next edge res<=A2D_res, cmplt[grant]=1 for one cycle, the round-robin pointer is updated, and the state returns to IDLE.
- Latency: reqN pulse in cycle k produces strt_cnv high in cycle k+2. cnv_cmplt in cycle m produces cmpltN and the new res in cycle m+1. The next strt_cnv is no earlier than cycle m+2.
- Simultaneous req0 and req1 in IDLE: both are pended. The winner follows the priority rule; the loser is granted immediately after the winner's completion.
- cnv_cmplt outside WAIT is ignored. res holds between completions.

Optional Feature:
- Macro: A2D_TIMEOUT_EN.
- Defined:
  - A 13-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TO_CYCLES-1 without cnv_cmplt: next edge res<=12'hFFF, cmplt[grant] pulses, to_err pulses for one cycle, state returns to IDLE.
  - cnv_cmplt in the same cycle as the terminal count takes precedence (normal completion, no to_err).
- Undefined: WAIT lasts indefinitely; no counter is built; to_err is tied to 0.

Test Plan:
- Reset release, then req0_strt with req0_chnnl=3'd2 -> strt_cnv one cycle two cycles later with chnnl=2. cnv_cmplt with A2D_res=12'h5A3 -> res=12'h5A3 and cmplt0 one cycle later; busy0 falls with it.
- req0 (ch 1) and req1 (ch 7) in the same cycle with FIXED_PRIO=0 from reset -> ch 1 converts first, then ch 7. A second simultaneous pair -> the winner alternates according to the round-robin rule. FIXED_PRIO=1 -> ch 1 always first.
- req1 (ch 4) then req1 (ch 6) before grant -> exactly one conversion, on ch 6; a single cmplt1.
- req0 pulsed during its own WAIT -> after cmplt0, busy0 stays 1 and a new strt_cnv follows two cycles after completion.
- rst_n asserted during WAIT, then cnv_cmplt pulsed after release -> no cmplt0/cmplt1; res=0; state IDLE.
- A2D_TIMEOUT_EN defined, TO_CYCLES=16, cnv_cmplt withheld -> after 16 WAIT cycles: res=12'hFFF, cmplt pulse, to_err pulse, state IDLE.

Source files
------------

// File: rtl/a2d_arbiter.sv
// Two-requester arbiter in front of the shared SPI A2D converter: buffers one request per
// requester, sequences strt_cnv/chnnl and returns the result. Optional macro: A2D_TIMEOUT_EN.
module a2d_arbiter #(
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned TO_CYCLES  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_strt,
    input  logic [2:0]  req0_chnnl,
    input  logic        req1_strt,
    input  logic [2:0]  req1_chnnl,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] A2D_res,
    output logic [11:0] res,
    output logic        cmplt0,
    output logic        cmplt1,
    output logic        busy0,
    output logic        busy1,
    output logic        to_err
);

    localparam int unsigned CH_W  = 3;
    localparam int unsigned RES_W = 12;

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t             state, state_nxt;
    logic               pend0, pend1, pend0_nxt, pend1_nxt;
    logic [CH_W-1:0]    ch0, ch1;
    logic               gnt, gnt_nxt;
    logic               last_gnt, last_nxt;
    logic [CH_W-1:0]    chnnl_nxt;
    logic [RES_W-1:0]   res_nxt;
    logic               strt_nxt, cmplt0_nxt, cmplt1_nxt, to_err_nxt;
    logic               busy0_nxt, busy1_nxt;
    logic               win_c;
    logic               done_c;
    logic               timeout_c;

    // Only meaningful values keep the 13-bit timeout counter consistent
    if (TO_CYCLES < 2 || TO_CYCLES > 8192) begin : g_bad_to_cycles
        $error("a2d_arbiter: TO_CYCLES must be in 2..8192");
    end

`ifdef A2D_TIMEOUT_EN
    localparam int unsigned CNT_W = 13;

    logic [CNT_W-1:0] to_cnt;

    // Cleared outside WAIT so it restarts from 0 on every entry to WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state != WAIT)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + CNT_W'(1);
    end

    assign timeout_c = (state == WAIT) && (to_cnt == CNT_W'(TO_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Winner selection: round-robin prefers the requester not granted last
    always_comb begin
        if (FIXED_PRIO != 0)
            win_c = ~pend0;
        else if (pend0 && pend1)
            win_c = ~last_gnt;
        else
            win_c = ~pend0;
    end

    always_comb begin
        state_nxt  = state;
        pend0_nxt  = pend0;
        pend1_nxt  = pend1;
        gnt_nxt    = gnt;
        last_nxt   = last_gnt;
        chnnl_nxt  = chnnl;
        res_nxt    = res;
        strt_nxt   = 1'b0;
        cmplt0_nxt = 1'b0;
        cmplt1_nxt = 1'b0;
        to_err_nxt = 1'b0;
        done_c     = 1'b0;

        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    state_nxt = START;
                    strt_nxt  = 1'b1;
                    gnt_nxt   = win_c;
                    chnnl_nxt = win_c ? ch1 : ch0;
                    if (win_c)
                        pend1_nxt = 1'b0;
                    else
                        pend0_nxt = 1'b0;
                end
            end
            START: state_nxt = WAIT;
            WAIT: begin
                if (cnv_cmplt) begin
                    res_nxt = A2D_res;
                    done_c  = 1'b1;
                end else if (timeout_c) begin
                    res_nxt    = {RES_W{1'b1}};
                    to_err_nxt = 1'b1;
                    done_c     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (done_c) begin
            state_nxt  = IDLE;
            last_nxt   = gnt;
            cmplt0_nxt = ~gnt;
            cmplt1_nxt = gnt;
        end

        // A new request wins over the clear from grant or completion
        if (req0_strt)
            pend0_nxt = 1'b1;
        if (req1_strt)
            pend1_nxt = 1'b1;

        busy0_nxt = pend0_nxt | ((state_nxt != IDLE) & ~gnt_nxt);
        busy1_nxt = pend1_nxt | ((state_nxt != IDLE) & gnt_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend0    <= 1'b0;
            pend1    <= 1'b0;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            chnnl    <= '0;
            res      <= '0;
            strt_cnv <= 1'b0;
            cmplt0   <= 1'b0;
            cmplt1   <= 1'b0;
            to_err   <= 1'b0;
            busy0    <= 1'b0;
            busy1    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend0    <= pend0_nxt;
            pend1    <= pend1_nxt;
            gnt      <= gnt_nxt;
            last_gnt <= last_nxt;
            chnnl    <= chnnl_nxt;
            res      <= res_nxt;
            strt_cnv <= strt_nxt;
            cmplt0   <= cmplt0_nxt;
            cmplt1   <= cmplt1_nxt;
            to_err   <= to_err_nxt;
            busy0    <= busy0_nxt;
            busy1    <= busy1_nxt;
        end
    end

    // Stored channels; a repeat request before grant simply overwrites
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch0 <= '0;
            ch1 <= '0;
        end else begin
            if (req0_strt)
                ch0 <= req0_chnnl;
            if (req1_strt)
                ch1 <= req1_chnnl;
        end
    end

endmodule
